uart_packet_parser: RTL and testbench
=====================================

Name: uart_packet_parser

Overview:
Consumes the byte stream from the UART receiver (data byte + one-cycle done strobe) and assembles framed command packets.
- Frame format: SYNC, ADDR, LEN, LEN payload bytes, CSUM.
- Checks the checksum, length and inter-byte timeout.
- Buffers the payload and presents a verified packet to the command layer, which reads the payload by index and releases it with an ack.

Parameters:
- SYNC_BYTE, 8'hA5: frame start marker.
- MAX_LEN, 16: maximum payload bytes, range 1..255; buffer depth.
- IDX_W, 4: rd_idx width; must satisfy 2^IDX_W >= MAX_LEN.
- TIMEOUT_CYC, 200000: clk cycles allowed between bytes inside a frame; minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- rx_data  in  8  received byte; valid when rx_done=1
- rx_done  in  1  one-cycle byte strobe from the UART receiver
- pkt_valid  out  1  verified packet held; stays high until pkt_ack
- pkt_ack  in  1  consumer releases the packet
- pkt_addr  out  8  ADDR field of the held packet
- pkt_len  out  8  LEN field of the held packet
- rd_idx  in  IDX_W  payload read index
- rd_data  out  8  payload[rd_idx], combinational from the buffer
- err_csum  out  1  one-cycle pulse: checksum mismatch
- err_len  out  1  one-cycle pulse: LEN > MAX_LEN
- err_tmo  out  1  one-cycle pulse: inter-byte timeout
- err_ovr  out  1  one-cycle pulse: byte dropped while a packet was held
- busy  out  1  high in any state other than HUNT

Behaviour:
- Reset: asynchronous, active-high. State goes to HUNT. pkt_valid, pkt_addr, pkt_len, all err_*, busy, sum, byte index and timeout counter all go to 0. The payload buffer is not reset.
- Reset asserted mid-frame abandons the frame; no error pulse is produced.
- States: HUNT, GET_ADDR, GET_LEN, PAYLOAD, GET_CSUM, HOLD. Every transition happens on a cycle where rx_done=1, except timeout and ack.
- HUNT:
  - rx_data==SYNC_BYTE goes to GET_ADDR.
  - Any other byte is ignored and the state stays in HUNT.
- GET_ADDR: latch the byte into the addr register, set sum=byte, go to GET_LEN.
- GET_LEN:
  - LEN > MAX_LEN: pulse err_len, go to HUNT.
  - LEN==0: go to GET_CSUM.
  - Otherwise: go to PAYLOAD, index=0.
  - In all cases sum += byte.
- PAYLOAD:
  - Each byte: buf[index] <= byte, sum += byte, index++.
  - After byte LEN-1, go to GET_CSUM.
- GET_CSUM:
  - byte==sum: load pkt_addr/pkt_len, set pkt_valid=1, go to HOLD.
  - Otherwise: pulse err_csum, go to HUNT.
- Checksum arithmetic: sum is 8-bit, modulo 256, covering ADDR + LEN + payload. SYNC and CSUM are excluded.
- HOLD:
  - pkt_ack=1: pkt_valid<=0 and go to HUNT on the next clock.
  - Any rx_done in HOLD, including the same cycle as pkt_ack, drops the byte and pulses err_ovr. The buffer is untouched.
  - pkt_ack outside HOLD is ignored.
- Latency: pkt_valid and err_csum/err_len rise on the clock edge after the rx_done cycle that carries the deciding byte. All err_* are high for exactly one cycle.
- Timeout:
  - The counter runs in GET_ADDR, GET_LEN, PAYLOAD and GET_CSUM.
  - It clears on entry to these states and on every rx_done.
  - When it reaches TIMEOUT_CYC-1 with no rx_done: pulse err_tmo, go to HUNT.
  - rx_done in that same cycle wins: the byte is processed and no timeout occurs.
  - The counter is held at 0 in HUNT and HOLD.
- Read port:
  - rd_data = buf[rd_idx] when rd_idx < pkt_len, otherwise 8'h00.
  - It is guaranteed meaningful only while pkt_valid=1. The buffer is not written in HOLD, so the data is stable while held.
- A SYNC_BYTE value inside ADDR, LEN, payload or CSUM is treated as data; there is no resync mid-frame.
- busy=0 only in HUNT.

Test Plan:
- Valid frame: A5 03 02 11 22 38.
  - pkt_valid rises 1 cycle after the 38 strobe, with pkt_addr=03, pkt_len=02.
  - rd_idx 0 gives 11, 1 gives 22, 2 gives 00.
  - pkt_ack drops pkt_valid next cycle; busy returns to 0.
- Errors and resync:
  - A5 03 02 11 22 39 gives one err_csum pulse and no pkt_valid.
  - Then 00 FF A5 07 00 07 gives pkt_valid, addr 07, len 0.
- Length and timeout, with MAX_LEN=16 and TIMEOUT_CYC=50:
  - A5 01 11 gives err_len.
  - A5 01 then 50 idle cycles gives err_tmo exactly 50 cycles after the 01 strobe.
  - A byte at cycle 49 gives no err_tmo.
- Overrun: while HOLD with payload 11 22, send byte 55, and also a byte coincident with pkt_ack.
  - Each dropped byte gives one err_ovr pulse.
  - rd_data stays 11/22 until the ack.
- Reset: assert rst after A5 03 04 AA.
  - All outputs go to 0 immediately, asynchronously.
  - After release, a full valid 16-byte frame (LEN=MAX_LEN) is accepted and all 16 payload bytes read back correctly.

Source files
------------

// File: rtl/uart_packet_parser_if.sv
// Byte-stream input, packet handshake and payload read port of the UART packet parser.
interface uart_packet_parser_if #(
  parameter int unsigned IDX_W = 4
);
  logic [7:0]       rx_data;
  logic             rx_done;
  logic             pkt_valid;
  logic             pkt_ack;
  logic [7:0]       pkt_addr;
  logic [7:0]       pkt_len;
  logic [IDX_W-1:0] rd_idx;
  logic [7:0]       rd_data;
  logic             err_csum;
  logic             err_len;
  logic             err_tmo;
  logic             err_ovr;
  logic             busy;

  // Byte source and command-layer consumer side.
  modport master (
    output rx_data, rx_done, pkt_ack, rd_idx,
    input  pkt_valid, pkt_addr, pkt_len, rd_data,
    input  err_csum, err_len, err_tmo, err_ovr, busy
  );

  // Parser side.
  modport slave (
    input  rx_data, rx_done, pkt_ack, rd_idx,
    output pkt_valid, pkt_addr, pkt_len, rd_data,
    output err_csum, err_len, err_tmo, err_ovr, busy
  );
endinterface

// File: rtl/uart_packet_parser.sv
// Assembles SYNC/ADDR/LEN/payload/CSUM frames from a UART byte stream,
// verifies them and holds the payload until the consumer acks.
module uart_packet_parser #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input logic                clk,
  input logic                rst,
  uart_packet_parser_if.slave bus
);

  localparam int unsigned     CNT_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_HUNT, S_GET_ADDR, S_GET_LEN, S_PAYLOAD, S_GET_CSUM, S_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       sum_q, sum_d;
  logic [7:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pkt_valid_q, pkt_valid_d;
  logic [7:0]       pkt_addr_q, pkt_addr_d;
  logic [7:0]       pkt_len_q, pkt_len_d;
  logic             err_csum_q, err_csum_d;
  logic             err_len_q, err_len_d;
  logic             err_tmo_q, err_tmo_d;
  logic             err_ovr_q, err_ovr_d;
  logic             buf_we;
  logic [7:0]       buf_q [MAX_LEN];
  logic             timed;

  // State and control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_HUNT;
      addr_q      <= '0;
      len_q       <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      pkt_valid_q <= 1'b0;
      pkt_addr_q  <= '0;
      pkt_len_q   <= '0;
      err_csum_q  <= 1'b0;
      err_len_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      err_ovr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_addr_q  <= pkt_addr_d;
      pkt_len_q   <= pkt_len_d;
      err_csum_q  <= err_csum_d;
      err_len_q   <= err_len_d;
      err_tmo_q   <= err_tmo_d;
      err_ovr_q   <= err_ovr_d;
    end
  end

  // Payload buffer; deliberately not reset.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[idx_q[IDX_W-1:0]] <= bus.rx_data;
  end

  // Next-state, checksum, timeout and error-pulse logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    cnt_d       = '0;
    pkt_valid_d = pkt_valid_q;
    pkt_addr_d  = pkt_addr_q;
    pkt_len_d   = pkt_len_q;
    err_csum_d  = 1'b0;
    err_len_d   = 1'b0;
    err_tmo_d   = 1'b0;
    err_ovr_d   = 1'b0;
    buf_we      = 1'b0;

    // Counter defaults to 0, which covers clear-on-entry, clear-on-byte and
    // hold-at-zero in HUNT/HOLD; a byte in the expiry cycle takes priority.
    timed = (state_q == S_GET_ADDR) || (state_q == S_GET_LEN) ||
            (state_q == S_PAYLOAD)  || (state_q == S_GET_CSUM);
    if (timed && !bus.rx_done) begin
      if (cnt_q == TMO_LAST) begin
        err_tmo_d = 1'b1;
        state_d   = S_HUNT;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      S_HUNT: begin
        if (bus.rx_done && bus.rx_data == SYNC_BYTE) state_d = S_GET_ADDR;
      end
      S_GET_ADDR: begin
        if (bus.rx_done) begin
          addr_d  = bus.rx_data;
          sum_d   = bus.rx_data;
          state_d = S_GET_LEN;
        end
      end
      S_GET_LEN: begin
        if (bus.rx_done) begin
          sum_d = sum_q + bus.rx_data;
          len_d = bus.rx_data;
          if (bus.rx_data > MAX_LEN_B) begin
            err_len_d = 1'b1;
            state_d   = S_HUNT;
          end else if (bus.rx_data == 8'h00) begin
            state_d = S_GET_CSUM;
          end else begin
            idx_d   = '0;
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (bus.rx_done) begin
          buf_we = 1'b1;
          sum_d  = sum_q + bus.rx_data;
          idx_d  = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) state_d = S_GET_CSUM;
        end
      end
      S_GET_CSUM: begin
        if (bus.rx_done) begin
          if (bus.rx_data == sum_q) begin
            pkt_valid_d = 1'b1;
            pkt_addr_d  = addr_q;
            pkt_len_d   = len_q;
            state_d     = S_HOLD;
          end else begin
            err_csum_d = 1'b1;
            state_d    = S_HUNT;
          end
        end
      end
      S_HOLD: begin
        if (bus.rx_done) err_ovr_d = 1'b1;
        if (bus.pkt_ack) begin
          pkt_valid_d = 1'b0;
          state_d     = S_HUNT;
        end
      end
      default: state_d = S_HUNT;
    endcase
  end

  // Payload read port: out-of-range indices read as zero.
  always_comb begin
    bus.rd_data = '0;
    if (8'(bus.rd_idx) < pkt_len_q) bus.rd_data = buf_q[bus.rd_idx];
  end

  assign bus.pkt_valid = pkt_valid_q;
  assign bus.pkt_addr  = pkt_addr_q;
  assign bus.pkt_len   = pkt_len_q;
  assign bus.err_csum  = err_csum_q;
  assign bus.err_len   = err_len_q;
  assign bus.err_tmo   = err_tmo_q;
  assign bus.err_ovr   = err_ovr_q;
  assign bus.busy      = (state_q != S_HUNT);

endmodule

// File: tb/tb_uart_packet_parser.sv
// Directed-vector bench for uart_packet_parser (MAX_LEN=16, TIMEOUT_CYC=50).
module tb_uart_packet_parser;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  uart_packet_parser_if #(.IDX_W(4)) bus ();

  uart_packet_parser #(
    .SYNC_BYTE   (8'hA5),
    .MAX_LEN     (16),
    .IDX_W       (4),
    .TIMEOUT_CYC (50)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Called at a falling edge; byte is sampled on the next rising edge and
  // the task returns at the falling edge after it.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({bus.pkt_valid, bus.busy, bus.err_csum, bus.err_len, bus.err_tmo, bus.err_ovr} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 000000",
        {bus.pkt_valid, bus.busy, bus.err_csum, bus.err_len, bus.err_tmo, bus.err_ovr});
    end
    checks++;
    if ({bus.pkt_addr, bus.pkt_len} !== 16'h0000) begin
      errors++; $display("FAIL reset_addr_len got %h exp 0000", {bus.pkt_addr, bus.pkt_len});
    end
  endtask

  task automatic test_valid_frame;
    send_byte(8'hA5);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL vf_busy got %b exp 1", bus.busy); end
    send_byte(8'h03); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
    checks++;
    if (bus.pkt_valid !== 1'b0) begin errors++; $display("FAIL vf_early_valid got %b exp 0", bus.pkt_valid); end
    send_byte(8'h38);
    checks++;
    if (bus.pkt_valid !== 1'b1) begin errors++; $display("FAIL vf_valid got %b exp 1", bus.pkt_valid); end
    checks++;
    if (bus.pkt_addr !== 8'h03) begin errors++; $display("FAIL vf_addr got %h exp 03", bus.pkt_addr); end
    checks++;
    if (bus.pkt_len !== 8'h02) begin errors++; $display("FAIL vf_len got %h exp 02", bus.pkt_len); end
    bus.rd_idx = 4'd0; #1;
    checks++;
    if (bus.rd_data !== 8'h11) begin errors++; $display("FAIL vf_rd0 got %h exp 11", bus.rd_data); end
    bus.rd_idx = 4'd1; #1;
    checks++;
    if (bus.rd_data !== 8'h22) begin errors++; $display("FAIL vf_rd1 got %h exp 22", bus.rd_data); end
    bus.rd_idx = 4'd2; #1;
    checks++;
    if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL vf_rd2 got %h exp 00", bus.rd_data); end
    @(negedge clk);
    bus.pkt_ack = 1'b1;
    @(negedge clk);
    bus.pkt_ack = 1'b0;
    checks++;
    if (bus.pkt_valid !== 1'b0) begin errors++; $display("FAIL vf_ack_valid got %b exp 0", bus.pkt_valid); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL vf_ack_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_errors_resync;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h39);
    checks++;
    if (bus.err_csum !== 1'b1) begin errors++; $display("FAIL csum_pulse got %b exp 1", bus.err_csum); end
    checks++;
    if (bus.pkt_valid !== 1'b0) begin errors++; $display("FAIL csum_valid got %b exp 0", bus.pkt_valid); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL csum_busy got %b exp 0", bus.busy); end
    send_byte(8'h00);
    checks++;
    if (bus.err_csum !== 1'b0) begin errors++; $display("FAIL csum_pulse_end got %b exp 0", bus.err_csum); end
    send_byte(8'hFF);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL hunt_ignore got %b exp 0", bus.busy); end
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00); send_byte(8'h07);
    checks++;
    if ({bus.pkt_valid, bus.pkt_addr, bus.pkt_len} !== {1'b1, 8'h07, 8'h00}) begin
      errors++; $display("FAIL zero_len_pkt got %b/%h/%h exp 1/07/00", bus.pkt_valid, bus.pkt_addr, bus.pkt_len);
    end
    bus.rd_idx = 4'd0; #1;
    checks++;
    if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL zero_len_rd got %h exp 00", bus.rd_data); end
    @(negedge clk);
    bus.pkt_ack = 1'b1;
    @(negedge clk);
    bus.pkt_ack = 1'b0;
  endtask

  task automatic test_len_error;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h11);
    checks++;
    if (bus.err_len !== 1'b1) begin errors++; $display("FAIL len_pulse got %b exp 1", bus.err_len); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL len_busy got %b exp 0", bus.busy); end
    @(negedge clk);
    checks++;
    if (bus.err_len !== 1'b0) begin errors++; $display("FAIL len_pulse_end got %b exp 0", bus.err_len); end
  endtask

  task automatic test_timeout;
    int early;
    early = 0;
    send_byte(8'hA5); send_byte(8'h01);
    for (int k = 1; k <= 49; k++) begin
      @(negedge clk);
      if (bus.err_tmo !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL tmo_early got %0d exp 0", early); end
    @(negedge clk);
    checks++;
    if (bus.err_tmo !== 1'b1) begin errors++; $display("FAIL tmo_pulse got %b exp 1", bus.err_tmo); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL tmo_busy got %b exp 0", bus.busy); end
    @(negedge clk);
    checks++;
    if (bus.err_tmo !== 1'b0) begin errors++; $display("FAIL tmo_pulse_end got %b exp 0", bus.err_tmo); end
  endtask

  task automatic test_timeout_boundary;
    send_byte(8'hA5); send_byte(8'h01);
    repeat (49) @(negedge clk);
    send_byte(8'h00);
    checks++;
    if ({bus.err_tmo, bus.busy} !== 2'b01) begin
      errors++; $display("FAIL tmo_boundary got tmo/busy %b exp 01", {bus.err_tmo, bus.busy});
    end
    send_byte(8'h01);
    checks++;
    if ({bus.pkt_valid, bus.pkt_addr, bus.pkt_len} !== {1'b1, 8'h01, 8'h00}) begin
      errors++; $display("FAIL tmo_boundary_pkt got %b/%h/%h exp 1/01/00", bus.pkt_valid, bus.pkt_addr, bus.pkt_len);
    end
    @(negedge clk);
    bus.pkt_ack = 1'b1;
    @(negedge clk);
    bus.pkt_ack = 1'b0;
  endtask

  task automatic test_overrun;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h38);
    send_byte(8'h55);
    checks++;
    if ({bus.err_ovr, bus.pkt_valid} !== 2'b11) begin
      errors++; $display("FAIL ovr_pulse got ovr/valid %b exp 11", {bus.err_ovr, bus.pkt_valid});
    end
    @(negedge clk);
    checks++;
    if (bus.err_ovr !== 1'b0) begin errors++; $display("FAIL ovr_pulse_end got %b exp 0", bus.err_ovr); end
    bus.rd_idx = 4'd0; #1;
    checks++;
    if (bus.rd_data !== 8'h11) begin errors++; $display("FAIL ovr_rd0 got %h exp 11", bus.rd_data); end
    bus.rd_idx = 4'd1; #1;
    checks++;
    if (bus.rd_data !== 8'h22) begin errors++; $display("FAIL ovr_rd1 got %h exp 22", bus.rd_data); end
    @(negedge clk);
    bus.pkt_ack = 1'b1;
    send_byte(8'h66);
    bus.pkt_ack = 1'b0;
    checks++;
    if ({bus.err_ovr, bus.pkt_valid, bus.busy} !== 3'b100) begin
      errors++; $display("FAIL ovr_ack got ovr/valid/busy %b exp 100", {bus.err_ovr, bus.pkt_valid, bus.busy});
    end
    @(negedge clk);
    checks++;
    if (bus.err_ovr !== 1'b0) begin errors++; $display("FAIL ovr_ack_end got %b exp 0", bus.err_ovr); end
  endtask

  task automatic test_reset_midframe;
    int bad;
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00); send_byte(8'h07);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.pkt_valid, bus.pkt_addr} !== {1'b0, 8'h00}) begin
      errors++; $display("FAIL rst_held got %b/%h exp 0/00", bus.pkt_valid, bus.pkt_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h04); send_byte(8'hAA);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.err_csum, bus.err_len, bus.err_tmo, bus.err_ovr, bus.pkt_valid} !== 6'b0) begin
      errors++; $display("FAIL rst_mid got %b exp 000000",
        {bus.busy, bus.err_csum, bus.err_len, bus.err_tmo, bus.err_ovr, bus.pkt_valid});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.err_csum, bus.err_tmo} !== 3'b0) begin
      errors++; $display("FAIL rst_release got %b exp 000", {bus.busy, bus.err_csum, bus.err_tmo});
    end
    send_byte(8'hA5); send_byte(8'h20); send_byte(8'h10);
    for (int i = 0; i < 16; i++) send_byte(8'(i * 17));
    send_byte(8'h28);
    checks++;
    if ({bus.pkt_valid, bus.pkt_addr, bus.pkt_len} !== {1'b1, 8'h20, 8'h10}) begin
      errors++; $display("FAIL full_pkt got %b/%h/%h exp 1/20/10", bus.pkt_valid, bus.pkt_addr, bus.pkt_len);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      bus.rd_idx = 4'(i); #1;
      if (bus.rd_data !== 8'(i * 17)) begin
        bad++; $display("FAIL full_rd idx %0d got %h exp %h", i, bus.rd_data, 8'(i * 17));
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL full_rd_total got %0d bad exp 0", bad); end
    @(negedge clk);
    bus.pkt_ack = 1'b1;
    @(negedge clk);
    bus.pkt_ack = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    bus.pkt_ack = 1'b0;
    bus.rd_idx  = '0;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_valid_frame;
    test_errors_resync;
    test_len_error;
    test_timeout;
    test_timeout_boundary;
    test_overrun;
    test_reset_midframe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
